conv_flatten_buffer: RTL
========================

# conv_flatten_buffer

Downstream stage of `conv_pooling_top`. It captures the per-kernel feature-map stream produced by the last conv/pool layer and stores one complete frame. It then emits that frame as a flattened, channel-major serial stream with a valid/ready handshake, for the dense (fully connected) layer. It also tells the conv pipeline when capture space is available.

## Interface
- `BitSize`, 4: width of one activation.
- `NumberOfK`, 8: number of kernels/channels from the conv stage.
- `ProcessingElements`, 4: lanes per cycle on `in_data`; `NumberOfK % ProcessingElements == 0`.
- `PixelsPerChannel`, 4: output pixels per channel per frame (2x2 for an 8x8 image after two stride-2 pools).
- `clk  input  1`: single clock; all state changes on its rising edge.
- `res_n  input  1`: reset, asynchronous, active-high (asserted = 1 despite the codebase name).
- `in_valid  input  NumberOfK`: bit k set = channel k present this cycle.
- `in_data  input  ProcessingElements*BitSize`: channel k carried on lane `k % ProcessingElements`.
- `in_ready  output  1`: capture space available; drives `out_ready` of the conv stage.
- `out_valid  output  1`: `out_data` holds a flattened element.
- `out_data  output  BitSize`: flattened element.
- `out_last  output  1`: high with the final element of a frame.
- `out_ready  input  1`: dense layer accepts the element.
- `overflow  output  1`: sticky error, set when input arrives while `in_ready` is low.

## Operation
- Storage: `PixelsPerChannel x NumberOfK` entries of `BitSize` bits; pixel counter `p`, 0..PixelsPerChannel-1.
- FSM states FILL and DRAIN. The reset state is FILL with `p = 0`.
- FILL:
  - `in_ready = 1`.
  - For every k with `in_valid[k]`, write `mem[p][k] = lane (k % PE)`.
  - When `in_valid[NumberOfK-1]` is set, the pixel is complete and `p` increments.
  - Completion of pixel `PixelsPerChannel-1` moves the FSM to DRAIN and resets `p` to 0.
- DRAIN:
  - `in_ready = 0`.
  - Read index `i = k*PixelsPerChannel + p`, running from 0 to `NumberOfK*PixelsPerChannel-1`, in channel-major order.
  - `i` advances on each `out_valid && out_ready`.
  - The handshake on the last index returns the FSM to FILL.
- Channel slots not written during a frame keep their previous contents. After reset they are 0.
- Input arriving with any `in_valid` bit set while `in_ready = 0` is dropped and sets `overflow`. `overflow` clears only on reset.
- No arithmetic is performed; data passes through bit-exact.

## Timing
- Reset values: `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_last = 0`, `overflow = 0`. The FSM is in FILL and all counters are 0.
- Capture writes complete on the edge where `in_valid` is sampled.
- The first `out_valid` appears in the cycle after the edge that captured the final channel of the final pixel (latency 1).
- `out_data`, `out_valid` and `out_last` are registered. Under stall (`out_ready = 0`) they hold stable and `i` does not advance.
- With `out_ready` held at 1, the frame drains in exactly `NumberOfK*PixelsPerChannel` cycles (32 at the defaults).
- `in_ready` rises in the cycle after the last handshake.
- Asserting `res_n` mid-frame or mid-drain immediately returns every output to its reset value and discards any partial frame.

## Configuration
- `CONV_FLATTEN_DOUBLE_BUFFER_EN`:
  - Defined: two storage banks in ping-pong. Capture into one bank proceeds while the other drains. `in_ready` is low only when both banks hold undrained frames. Frames drain in capture order.
  - Undefined: a single bank. `in_ready` is low for the whole of DRAIN.

## Test plan
- Single frame, defaults. Send 4 pixels as 2 cycles each with `in_valid = 8'h0F` then `8'hF0`; data equals `(p*8+k) mod 16`. Expect 32 outputs in order `k*4+p`. First value `0`, then `8, 0, 8, 1, ...`. `out_last` is high only on the 32nd output.
- Backpressure: toggle `out_ready` every cycle during drain. Expect `out_data` held stable through each stall, no element lost or duplicated, and drain taking 63 cycles.
- Overflow (macro undefined): assert `in_valid = 8'h0F` during DRAIN. Expect `overflow = 1` that stays sticky, and unchanged drained data.
- Reset mid-drain: assert `res_n` after 10 outputs. Expect `out_valid = 0` and `in_ready = 1` immediately. A new frame then drains from index 0.
- Partial valid: a pixel delivered as `8'h03`, `8'h0C`, `8'h30`, `8'hC0` over 4 cycles. Expect identical output to the 2-cycle delivery, with `p` advancing only on the `8'hC0` cycle.
- Double buffer (macro defined): stream 2 frames back-to-back with `out_ready = 1`. Expect `in_ready` to stay 1 throughout and 64 ordered outputs, with `out_last` on the 32nd and 64th.

Source files
------------

// File: rtl/conv_flatten_buffer_if.sv
// Handshake bundle between the conv/pool capture side, the flatten buffer and
// the dense-layer consumer. The buffer itself uses the slave modport.
interface conv_flatten_buffer_if #(
  parameter int BitSize            = 4,
  parameter int NumberOfK          = 8,
  parameter int ProcessingElements = 4
) ();
  logic [NumberOfK-1:0]                  in_valid;
  logic [ProcessingElements*BitSize-1:0] in_data;
  logic                                  in_ready;
  logic                                  out_valid;
  logic [BitSize-1:0]                    out_data;
  logic                                  out_last;
  logic                                  out_ready;
  logic                                  overflow;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, overflow
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, overflow
  );
endinterface

// File: rtl/conv_flatten_buffer.sv
// conv_flatten_buffer: captures one frame of per-kernel feature-map pixels and
// replays it as a channel-major serial stream (index k*PixelsPerChannel + p).
// Optional macro CONV_FLATTEN_DOUBLE_BUFFER_EN adds a second storage bank so
// capture of the next frame overlaps the drain of the current one.
// res_n is an asynchronous, active-high reset despite its name.
module conv_flatten_buffer #(
  parameter int BitSize            = 4,
  parameter int NumberOfK          = 8,
  parameter int ProcessingElements = 4,
  parameter int PixelsPerChannel   = 4
) (
  input logic                  clk,
  input logic                  res_n,
  conv_flatten_buffer_if.slave bus
);

  localparam int BW = BitSize;
  localparam int NK = NumberOfK;
  localparam int PE = ProcessingElements;
  localparam int PPC = PixelsPerChannel;
`ifdef CONV_FLATTEN_DOUBLE_BUFFER_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int PW    = (PPC > 1) ? $clog2(PPC) : 1;
  localparam int KW    = (NK > 1) ? $clog2(NK) : 1;
  localparam int DEPTH = NB * PPC * NK;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PPC - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NK - 1);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  // Flat storage: entry = (bank * PPC + pixel) * NK + channel.
  function automatic logic [AW-1:0] addr_f(input logic bank,
                                           input logic [PW-1:0] p,
                                           input logic [KW-1:0] k);
    int a;
    a = ((int'(bank) * PPC) + int'(p)) * NK + int'(k);
    return AW'(a);
  endfunction

  // Channel k always rides on lane k mod PE.
  function automatic logic [BW-1:0] lane_f(input logic [PE*BW-1:0] data,
                                           input int k);
    return data[(k % PE)*BW +: BW];
  endfunction

  logic [BW-1:0] mem_q [DEPTH];

  state_e        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [KW-1:0] rd_k_q, rd_k_d;
  logic [PW-1:0] rd_p_q, rd_p_d;
  logic          out_valid_q, out_valid_d;
  logic [BW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          in_ready_q, in_ready_d;
  logic          overflow_q, overflow_d;

  logic [NK-1:0] wr_en_s;
  logic          pix_done_s;
  logic          frame_done_s;
  logic          hs_s;
  logic          rd_last_s;
  logic          start_s;
  logic          load_s;
  logic          rd_done_s;
  logic          wr_bank_s;
  logic          rd_bank_s;
  logic [AW-1:0] rd_addr_s;
  logic [BW-1:0] rd_data_s;

`ifdef CONV_FLATTEN_DOUBLE_BUFFER_EN
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;

  assign wr_bank_s = wr_bank_q;
  assign rd_bank_s = rd_bank_q;
  // Drain the oldest frame: one already parked, or the one completing now.
  assign start_s   = full_q[rd_bank_q] | (frame_done_s & (wr_bank_q == rd_bank_q));
`else
  assign wr_bank_s = 1'b0;
  assign rd_bank_s = 1'b0;
  assign start_s   = frame_done_s;
`endif

  // Capture is gated by the registered ready so dropped beats never land in storage.
  assign wr_en_s      = in_ready_q ? bus.in_valid : {NK{1'b0}};
  assign pix_done_s   = in_ready_q & bus.in_valid[NK-1];
  assign frame_done_s = pix_done_s & (p_q == P_LAST);
  assign hs_s         = out_valid_q & bus.out_ready;
  assign rd_last_s    = (rd_k_q == K_LAST) & (rd_p_q == P_LAST);

  // Pixel counter, drain index and output sequencing.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    rd_k_d      = rd_k_q;
    rd_p_d      = rd_p_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    load_s      = 1'b0;
    rd_done_s   = 1'b0;

    if (pix_done_s) begin
      p_d = frame_done_s ? {PW{1'b0}} : (p_q + PW'(1));
    end else begin
      p_d = p_q;
    end

    case (state_q)
      S_FILL: begin
        if (start_s) begin
          state_d     = S_DRAIN;
          rd_k_d      = {KW{1'b0}};
          rd_p_d      = {PW{1'b0}};
          out_valid_d = 1'b1;
          out_last_d  = (NK == 1) && (PPC == 1);
          load_s      = 1'b1;
        end else begin
          state_d = S_FILL;
        end
      end
      S_DRAIN: begin
        if (hs_s) begin
          if (rd_last_s) begin
            state_d     = S_FILL;
            rd_k_d      = {KW{1'b0}};
            rd_p_d      = {PW{1'b0}};
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rd_done_s   = 1'b1;
          end else begin
            if (rd_p_q == P_LAST) begin
              rd_p_d = {PW{1'b0}};
              rd_k_d = rd_k_q + KW'(1);
            end else begin
              rd_p_d = rd_p_q + PW'(1);
              rd_k_d = rd_k_q;
            end
            out_last_d = (rd_k_d == K_LAST) && (rd_p_d == P_LAST);
            load_s     = 1'b1;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d     = S_FILL;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // Storage read for the next output element, forwarding a same-cycle capture.
  always_comb begin
    rd_addr_s = addr_f(rd_bank_s, rd_p_d, rd_k_d);
    rd_data_s = mem_q[rd_addr_s];
    for (int k = 0; k < NK; k++) begin
      rd_data_s = (wr_en_s[k] && (addr_f(wr_bank_s, p_q, KW'(k)) == rd_addr_s))
                  ? lane_f(bus.in_data, k) : rd_data_s;
    end
    out_data_d = load_s ? rd_data_s : out_data_q;
  end

  // Capture-space tracking, ready generation and sticky overflow.
  always_comb begin
    overflow_d = overflow_q | (~in_ready_q & (|bus.in_valid));
`ifdef CONV_FLATTEN_DOUBLE_BUFFER_EN
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (frame_done_s) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end else begin
      wr_bank_d = wr_bank_q;
    end
    if (rd_done_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
    in_ready_d = ~full_d[wr_bank_d];
`else
    in_ready_d = (state_d == S_FILL);
`endif
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      state_q     <= S_FILL;
      p_q         <= {PW{1'b0}};
      rd_k_q      <= {KW{1'b0}};
      rd_p_q      <= {PW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {BW{1'b0}};
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      overflow_q  <= 1'b0;
`ifdef CONV_FLATTEN_DOUBLE_BUFFER_EN
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      rd_k_q      <= rd_k_d;
      rd_p_q      <= rd_p_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      overflow_q  <= overflow_d;
`ifdef CONV_FLATTEN_DOUBLE_BUFFER_EN
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
`endif
    end
  end

  // Frame storage; slots not written in a frame keep their old value.
  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= {BW{1'b0}};
      end
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (wr_en_s[k]) begin
          mem_q[addr_f(wr_bank_s, p_q, KW'(k))] <= lane_f(bus.in_data, k);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.overflow  = overflow_q;

endmodule
